// File: rtl/lsu.sv
// Load/store unit: turns decoder memory controls into one or two word-aligned
// handshaked bus beats, stalls the core until completion, and extends load data.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_wren_i,
  input  logic [2:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              stall_o,
  output logic              rsp_valid_o,
  output logic [31:0]       ld_data_o,
  output logic              err_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic              wren, err;
  logic [1:0]        off;
  logic [ADDR_W-1:0] base;
  logic [63:0]       wdata_sh;
  logic [7:0]        lane;
  logic [31:0]       rdata0, rdata1;

  logic              illegal;
  logic [3:0]        size;
  logic [31:0]       size_bits;
  logic              accept;

  assign accept = (state == IDLE) && req_valid_i;

  always_comb begin
    case (req_op_i[1:0])
      2'b00:   size = 4'b0001;
      2'b01:   size = 4'b0011;
      2'b10:   size = 4'b1111;
      default: size = 4'b0000;
    endcase
  end

  // Store data is trimmed to the access size so disabled lanes read as zero.
  assign size_bits = {{8{size[3]}}, {8{size[2]}}, {8{size[1]}}, {8{size[0]}}}
                   & {32{req_wren_i}};

  assign illegal = req_wren_i ? (req_op_i[2] || (req_op_i[1:0] == 2'b11))
                              : ((req_op_i[1:0] == 2'b11) || (req_op_i[2:1] == 2'b11));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = illegal ? DONE : REQ0;
      REQ0:    if (mem_gnt_i) state_nxt = WAIT0;
      WAIT0:   if (mem_rvalid_i) state_nxt = (lane[7:4] != 4'b0000) ? REQ1 : DONE;
      REQ1:    if (mem_gnt_i) state_nxt = WAIT1;
      WAIT1:   if (mem_rvalid_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      op       <= '0;
      wren     <= 1'b0;
      err      <= 1'b0;
      off      <= '0;
      base     <= '0;
      wdata_sh <= '0;
      lane     <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op       <= req_op_i;
        wren     <= req_wren_i;
        err      <= illegal;
        off      <= req_addr_i[1:0];
        base     <= {req_addr_i[ADDR_W-1:2], 2'b00};
        wdata_sh <= {32'b0, req_wdata_i & size_bits} << {req_addr_i[1:0], 3'b000};
        lane     <= {4'b0000, size} << req_addr_i[1:0];
        rdata0   <= '0;
        rdata1   <= '0;
      end
      if ((state == WAIT0) && mem_rvalid_i) rdata0 <= mem_rdata_i;
      if ((state == WAIT1) && mem_rvalid_i) rdata1 <= mem_rdata_i;
    end
  end

  logic req0, req1, done;
  assign req0 = (state == REQ0);
  assign req1 = (state == REQ1);
  assign done = (state == DONE);

  // Bus outputs decode state and registers only; zero outside a request.
  assign mem_req_o   = req0 || req1;
  assign mem_we_o    = mem_req_o && wren;
  assign mem_addr_o  = req0 ? base : (req1 ? base + ADDR_W'(4) : '0);
  assign mem_be_o    = req0 ? lane[3:0] : (req1 ? lane[7:4] : 4'b0000);
  assign mem_wdata_o = req0 ? wdata_sh[31:0] : (req1 ? wdata_sh[63:32] : 32'b0);

  logic [31:0] rw, ext;
  assign rw = 32'({rdata1, rdata0} >> {off, 3'b000});

  always_comb begin
    case (op)
      3'b000:  ext = {{24{rw[7]}}, rw[7:0]};
      3'b001:  ext = {{16{rw[15]}}, rw[15:0]};
      3'b100:  ext = {24'b0, rw[7:0]};
      3'b101:  ext = {16'b0, rw[15:0]};
      default: ext = rw;
    endcase
  end

  assign rsp_valid_o = done;
  assign err_o       = done && err;
  assign ld_data_o   = (done && !wren && !err) ? ext : 32'b0;
  assign stall_o     = req_valid_i && !done;

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu: expected beats and responses are queued
// when each request is driven and popped as the bus model sees them.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_wren_i;
  logic [2:0]  req_op_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        stall_o, rsp_valid_o, err_o;
  logic [31:0] ld_data_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  rsp_t        rsp_q[$];

  lsu #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_wren_i(req_wren_i), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .rsp_valid_o(rsp_valid_o), .ld_data_o(ld_data_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                           input logic [31:0] wd, input logic [31:0] rd);
    beat_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    beat_q.push_back(b);
    rd_q.push_back(rd);
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e, input int cyc);
    rsp_t r;
    r.data = d; r.err = e; r.cyc = cyc;
    rsp_q.push_back(r);
  endtask

  // Drives one request and plays the bus; gwait = grant-stall cycles per beat.
  task automatic access(input string name, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input int gwait);
    int    cyc, gw;
    bit    done, pend;
    beat_t b;
    rsp_t  r;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_wren_i = we; req_op_i = op; req_addr_i = addr; req_wdata_i = wd;
    #1 check({name, ".stall_c0"}, 32'(stall_o), 32'd1);
    cyc = 0; done = 0; pend = 0; gw = gwait;
    while (!done && cyc < 40) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      // Scrambling req_* after acceptance must not matter.
      req_addr_i = $urandom; req_wdata_i = $urandom;
      if (pend) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        pend = 0;
        check({name, ".req_in_wait"}, 32'(mem_req_o), 32'd0);
      end
      #1;
      check({name, ".stall"}, 32'(stall_o), 32'(!rsp_valid_o));
      if (mem_req_o) begin
        if (beat_q.size() == 0) begin
          check({name, ".unexpected_req"}, 32'(mem_req_o), 32'd0);
        end else begin
          b = beat_q[0];
          check({name, ".addr"},  mem_addr_o,  b.addr);
          check({name, ".be"},    32'(mem_be_o), 32'(b.be));
          check({name, ".we"},    32'(mem_we_o), 32'(b.we));
          check({name, ".wdata"}, mem_wdata_o, b.wdata);
          if (gw > 0) gw--;
          else begin
            void'(beat_q.pop_front());
            mem_gnt_i = 1'b1;
            pend = 1;
            gw = gwait;
          end
        end
      end
      if (rsp_valid_o) begin
        done = 1;
        if (rsp_q.size() == 0) check({name, ".unexpected_rsp"}, 32'(rsp_valid_o), 32'd0);
        else begin
          r = rsp_q.pop_front();
          check({name, ".ld_data"}, ld_data_o, r.data);
          check({name, ".err"},     32'(err_o), 32'(r.err));
          check({name, ".rsp_cyc"}, 32'(cyc), 32'(r.cyc));
        end
      end
    end
    if (!done) check({name, ".timeout"}, 32'd0, 32'd1);
    check({name, ".beats_left"}, 32'(beat_q.size()), 32'd0);
    req_valid_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_wren_i = 1'b0; req_op_i = 3'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #12;
    check("rst.mem_req",   32'(mem_req_o), 32'd0);
    check("rst.mem_be",    32'(mem_be_o), 32'd0);
    check("rst.mem_addr",  mem_addr_o, 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst.ld_data",   ld_data_o, 32'd0);
    check("rst.stall_lo",  32'(stall_o), 32'd0);
    req_valid_i = 1'b1;
    #1 check("rst.stall_hi", 32'(stall_o), 32'd1);
    req_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;

    // Aligned LW
    push_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);
    push_rsp(32'hDEADBEEF, 1'b0, 3);
    access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0);

    // LB / LBU at top byte
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000);
    push_rsp(32'hFFFFFF80, 1'b0, 3);
    access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0);
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000);
    push_rsp(32'h00000080, 1'b0, 3);
    access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0);

    // LHU inside a word at offset 1
    push_beat(32'h300, 4'b0110, 1'b0, 32'h0, 32'h00ABCD00);
    push_rsp(32'h0000ABCD, 1'b0, 3);
    access("lhu", 1'b0, 3'b101, 32'h301, 32'h0, 0);

    // Misaligned SW splits
    push_beat(32'h100, 4'b1100, 1'b1, 32'h33440000, 32'h0);
    push_beat(32'h104, 4'b0011, 1'b1, 32'h00001122, 32'h0);
    push_rsp(32'h0, 1'b0, 5);
    access("sw_split", 1'b1, 3'b010, 32'h102, 32'h11223344, 0);

    // SB keeps only its byte lane
    push_beat(32'h100, 4'b0010, 1'b1, 32'h00004400, 32'h0);
    push_rsp(32'h0, 1'b0, 3);
    access("sb", 1'b1, 3'b000, 32'h101, 32'h11223344, 0);

    // LH wrapping past the top of the address space
    push_beat(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 32'hAB000000);
    push_beat(32'h00000000, 4'b0001, 1'b0, 32'h0, 32'h000000CD);
    push_rsp(32'hFFFFCDAB, 1'b0, 5);
    access("lh_wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 0);

    // SH with 3 cycles of grant wait
    push_beat(32'h200, 4'b0011, 1'b1, 32'h0000BEEF, 32'h0);
    push_rsp(32'h0, 1'b0, 6);
    access("sh_gwait", 1'b1, 3'b001, 32'h200, 32'h0000BEEF, 3);

    // Illegal load op and illegal store op
    push_rsp(32'h0, 1'b1, 1);
    access("ld_ill", 1'b0, 3'b011, 32'h100, 32'h0, 0);
    push_rsp(32'h0, 1'b1, 1);
    access("st_ill", 1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, 0);

    // Reset in WAIT0 abandons the access
    @(negedge clk_i);
    req_valid_i = 1'b1; req_wren_i = 1'b1; req_op_i = 3'b001;
    req_addr_i = 32'h200; req_wdata_i = 32'h0000BEEF;
    @(posedge clk_i); @(negedge clk_i);
    check("rstmid.req_c1", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    mem_gnt_i = 1'b0;
    check("rstmid.req_wait0", 32'(mem_req_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    check("rstmid.mem_req",   32'(mem_req_o), 32'd0);
    check("rstmid.mem_we",    32'(mem_we_o), 32'd0);
    check("rstmid.mem_be",    32'(mem_be_o), 32'd0);
    check("rstmid.mem_addr",  mem_addr_o, 32'd0);
    check("rstmid.mem_wdata", mem_wdata_o, 32'd0);
    check("rstmid.rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rstmid.stall",     32'(stall_o), 32'd1);
    req_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    @(posedge clk_i); @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    check("rstmid.stray_rsp", 32'(rsp_valid_o), 32'd0);
    check("rstmid.stray_req", 32'(mem_req_o), 32'd0);

    // Unit is usable after the abandoned access
    push_beat(32'h400, 4'b0100, 1'b0, 32'h0, 32'h007F0000);
    push_rsp(32'h0000007F, 1'b0, 3);
    access("lb_after_rst", 1'b0, 3'b000, 32'h402, 32'h0, 0);

    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
